// File: rtl/ctrl_decode_queue.sv
// Instruction decoder feeding a DEPTH-entry queue of decoded control words, with a RUN/HALTED FSM.
// Build option: define CTRL_ILLEGAL_TRAP_EN to flag illegal opcodes with err and halt on them.
module ctrl_decode_queue #(
  parameter int IW    = 16,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] instr,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    alu_src,
  output logic          mem_write,
  output logic          mem_read,
  output logic          reg_write,
  output logic          mem_to_reg,
  output logic [2:0]    wr_reg,
  output logic          halt,
  output logic          err,
  output logic          halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [2:0] alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       mem_to_reg;
    logic [2:0] wr_reg;
    logic       halt;
    logic       err;
  } entry_t;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  function automatic entry_t decode(input logic [IW-1:0] ins);
    entry_t e;
    e         = '0;
    e.alu_src = 3'd5;
    case (ins[IW-1:IW-5])
      5'b01000, 5'b01001: begin e.alu_src = 3'd1; e.reg_write = 1'b1; e.wr_reg = ins[7:5]; end
      5'b01010, 5'b01011: begin e.alu_src = 3'd2; e.reg_write = 1'b1; e.wr_reg = ins[7:5]; end
      5'b10000: begin e.alu_src = 3'd1; e.mem_write = 1'b1; end
      5'b10001: begin
        e.alu_src = 3'd1; e.mem_read = 1'b1; e.reg_write = 1'b1;
        e.mem_to_reg = 1'b1; e.wr_reg = ins[7:5];
      end
      5'b11000: begin e.alu_src = 3'd3; e.reg_write = 1'b1; e.wr_reg = ins[10:8]; end
      5'b11011: begin e.alu_src = 3'd0; e.reg_write = 1'b1; e.wr_reg = ins[4:2]; end
      5'b00110: begin e.alu_src = 3'd5; e.reg_write = 1'b1; e.wr_reg = 3'b111; end
      5'b00001: begin e.alu_src = 3'd5; end
      5'b00000: begin e.halt = 1'b1; end
`ifdef CTRL_ILLEGAL_TRAP_EN
      default:  begin e.err = 1'b1; end
`else
      default:  begin e.err = 1'b0; end
`endif
    endcase
    return e;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  state_t         state_q, state_d;

  entry_t dec_s;
  entry_t head_s;
  logic   push_s;
  logic   pop_s;
  logic   unused_s;

  assign unused_s  = ^instr;
  assign dec_s     = decode(instr);
  assign in_ready  = (count_q < CW'(DEPTH)) && (state_q == RUN) && !flush;
  assign out_valid = (count_q != '0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign head_s    = out_valid ? mem_q[rd_ptr_q] : '0;

  assign alu_src    = head_s.alu_src;
  assign mem_write  = head_s.mem_write;
  assign mem_read   = head_s.mem_read;
  assign reg_write  = head_s.reg_write;
  assign mem_to_reg = head_s.mem_to_reg;
  assign wr_reg     = head_s.wr_reg;
  assign halt       = head_s.halt;
  assign err        = head_s.err;
  assign halted     = (state_q == HALTED);

  // Next-state: queue storage, pointers, occupancy and FSM; flush discards everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = dec_s;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // err is only ever set when illegal opcodes trap, so it halts exactly like HALT.
      if (push_s && (dec_s.halt || dec_s.err)) begin
        state_d = HALTED;
      end else begin
        state_d = state_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= RUN;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

endmodule
